// File: rtl/regf_bus_initiator.sv
// Command/response initiator for the regf mem_* bus: one single-cycle access per command.
// Optional read-modify-write with per-bit write mask when REGF_INIT_RMW_EN is defined.
module regf_bus_initiator #(
  parameter int AW  = 13,
  parameter int DW  = 32,
  parameter int ECW = 8
) (
  input  logic           main_clk_i,
  input  logic           main_rst_an_i,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [AW-1:0]  cmd_addr_i,
  input  logic           cmd_write_i,
  input  logic [DW-1:0]  cmd_wdata_i,
`ifdef REGF_INIT_RMW_EN
  input  logic [DW-1:0]  cmd_wmask_i,
`endif
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [DW-1:0]  rsp_rdata_o,
  output logic           rsp_err_o,
  output logic           mem_ena_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic           mem_wena_o,
  output logic [DW-1:0]  mem_wdata_o,
  input  logic [DW-1:0]  mem_rdata_i,
  input  logic           mem_err_i,
  output logic           busy_o,
  output logic [ECW-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_RSP
`ifdef REGF_INIT_RMW_EN
    , ST_RMW_RD
`endif
  } state_t;

  state_t         state_reg, state_next;
  logic           mem_ena_reg, mem_ena_next;
  logic           mem_wena_reg, mem_wena_next;
  logic [AW-1:0]  mem_addr_reg, mem_addr_next;
  logic [DW-1:0]  mem_wdata_reg, mem_wdata_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0]  rsp_rdata_reg, rsp_rdata_next;
  logic           rsp_err_reg, rsp_err_next;
  logic [ECW-1:0] err_cnt_reg, err_cnt_next;
  logic           cmd_fire;
`ifdef REGF_INIT_RMW_EN
  logic [DW-1:0]  wmask_reg, wmask_next;
  logic           rmw_reg, rmw_next;
`endif

  assign cmd_ready_o = (state_reg == ST_IDLE) || ((state_reg == ST_RSP) && rsp_ready_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_next     = state_reg;
    mem_ena_next   = mem_ena_reg;
    mem_wena_next  = mem_wena_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    err_cnt_next   = err_cnt_reg;
`ifdef REGF_INIT_RMW_EN
    wmask_next     = wmask_reg;
    rmw_next       = rmw_reg;
`endif

    case (state_reg)
      ST_IDLE: ;
      ST_ACC: begin
        mem_ena_next   = 1'b0;
        mem_wena_next  = 1'b0;
        rsp_valid_next = 1'b1;
        rsp_err_next   = mem_err_i;
        rsp_rdata_next = mem_wena_reg ? '0 : mem_rdata_i;
`ifdef REGF_INIT_RMW_EN
        // RMW writes report the old value captured during the read phase
        if (rmw_reg) rsp_rdata_next = rsp_rdata_reg;
`endif
        state_next     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
`ifdef REGF_INIT_RMW_EN
      ST_RMW_RD: begin
        if (mem_err_i) begin
          mem_ena_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          state_next     = ST_RSP;
        end else begin
          mem_wena_next  = 1'b1;
          mem_wdata_next = (mem_rdata_i & ~wmask_reg) | (mem_wdata_reg & wmask_reg);
          rsp_rdata_next = mem_rdata_i;
          rmw_next       = 1'b1;
          state_next     = ST_ACC;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase

    // Acceptance is shared by IDLE and the RSP fast path
    if (cmd_fire) begin
      mem_ena_next   = 1'b1;
      mem_wena_next  = cmd_write_i;
      mem_addr_next  = cmd_addr_i;
      mem_wdata_next = cmd_wdata_i;
      state_next     = ST_ACC;
`ifdef REGF_INIT_RMW_EN
      wmask_next     = cmd_wmask_i;
      rmw_next       = 1'b0;
      if (cmd_write_i && (cmd_wmask_i != '1)) begin
        mem_wena_next = 1'b0;
        state_next    = ST_RMW_RD;
      end
`endif
    end

    if (mem_ena_reg && mem_err_i && (err_cnt_reg != '1))
      err_cnt_next = err_cnt_reg + ECW'(1);
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_reg     <= ST_IDLE;
      mem_ena_reg   <= 1'b0;
      mem_wena_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
`ifdef REGF_INIT_RMW_EN
      wmask_reg     <= '0;
      rmw_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_ena_reg   <= mem_ena_next;
      mem_wena_reg  <= mem_wena_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      err_cnt_reg   <= err_cnt_next;
`ifdef REGF_INIT_RMW_EN
      wmask_reg     <= wmask_next;
      rmw_reg       <= rmw_next;
`endif
    end
  end

  assign mem_ena_o   = mem_ena_reg;
  assign mem_wena_o  = mem_wena_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_regf_bus_initiator.sv
// Directed bench for regf_bus_initiator; RMW step only when REGF_INIT_RMW_EN is defined.
module tb_regf_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_wdata, cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ena, mem_wena, mem_err;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regf_bus_initiator #(.AW(13), .DW(32), .ECW(8)) dut (
    .main_clk_i   (clk),
    .main_rst_an_i(rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_write_i  (cmd_write),
    .cmd_wdata_i  (cmd_wdata),
`ifdef REGF_INIT_RMW_EN
    .cmd_wmask_i  (cmd_wmask),
`endif
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_ena_o    (mem_ena),
    .mem_addr_o   (mem_addr),
    .mem_wena_o   (mem_wena),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err),
    .busy_o       (busy),
    .err_cnt_o    (err_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '1; rsp_ready = 1'b1; mem_rdata = '0; mem_err = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_mem_ena",   32'(mem_ena),   32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_err_cnt",   32'(err_cnt),   32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    rst_n = 1'b1;
    step;

    // T1 write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h000; cmd_wdata = 32'h1;
    step;
    cmd_valid = 1'b0;
    chk("t1_mem_ena",   32'(mem_ena),   32'h1);
    chk("t1_mem_wena",  32'(mem_wena),  32'h1);
    chk("t1_mem_addr",  32'(mem_addr),  32'h0);
    chk("t1_mem_wdata", mem_wdata,      32'h1);
    chk("t1_busy",      32'(busy),      32'h1);
    step;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_err",   32'(rsp_err),   32'h0);
    chk("t1_rsp_rdata", rsp_rdata,      32'h0);
    chk("t1_ena_off",   32'(mem_ena),   32'h0);
    chk("t1_wena_off",  32'(mem_wena),  32'h0);
    step;
    chk("t1_idle_busy", 32'(busy),      32'h0);
    chk("t1_idle_rspv", 32'(rsp_valid), 32'h0);

    // T2 back-to-back reads, one access every 2 cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h000;
    step;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'h10 + 32'(i);
      chk("t2_mem_ena",   32'(mem_ena),   32'h1);
      chk("t2_mem_wena",  32'(mem_wena),  32'h0);
      step;
      chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t2_rsp_rdata", rsp_rdata,      32'h10 + 32'(i));
      chk("t2_no_ena",    32'(mem_ena),   32'h0);
      chk("t2_cmd_ready", 32'(cmd_ready), 32'h1);
      if (i == 2) cmd_valid = 1'b0;
      step;
    end
    chk("t2_idle", 32'(busy), 32'h0);

    // T3 error read and counter saturation
    mem_err = 1'b1; mem_rdata = 32'hDEAD;
    cmd_valid = 1'b1; cmd_addr = 13'h004;
    step;
    cmd_valid = 1'b0;
    chk("t3_mem_addr", 32'(mem_addr), 32'h4);
    step;
    chk("t3_rsp_err",  32'(rsp_err),  32'h1);
    chk("t3_err_cnt",  32'(err_cnt),  32'h1);
    step;
    chk("t3_addr_hold", 32'(mem_addr), 32'h4);
    cmd_valid = 1'b1;
    repeat (600) step;
    cmd_valid = 1'b0;
    repeat (3) step;
    chk("t3_err_sat", 32'(err_cnt), 32'hFF);
    chk("t3_idle",    32'(busy),    32'h0);
    mem_err = 1'b0;

    // T4 response backpressure
    rsp_ready = 1'b0; mem_rdata = 32'h55; cmd_addr = 13'h008; cmd_valid = 1'b1;
    step;
    step;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_rdata", rsp_rdata,      32'h55);
    mem_rdata = 32'h66;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t4_hold_valid", 32'(rsp_valid), 32'h1);
      chk("t4_hold_rdata", rsp_rdata,      32'h55);
      chk("t4_cmd_ready",  32'(cmd_ready), 32'h0);
      chk("t4_no_ena",     32'(mem_ena),   32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_ready_pass", 32'(cmd_ready), 32'h1);
    step;
    cmd_valid = 1'b0;
    chk("t4_next_ena", 32'(mem_ena), 32'h1);
    step;
    chk("t4_next_rdata", rsp_rdata, 32'h66);
    step;

`ifdef REGF_INIT_RMW_EN
    // T5 masked write: read, merge, write back
    mem_rdata = 32'h10; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 13'h00C; cmd_wdata = 32'h1; cmd_wmask = 32'h1;
    step;
    cmd_valid = 1'b0; cmd_wmask = '1;
    chk("t5_rd_ena",   32'(mem_ena),  32'h1);
    chk("t5_rd_wena",  32'(mem_wena), 32'h0);
    step;
    chk("t5_wr_ena",   32'(mem_ena),  32'h1);
    chk("t5_wr_wena",  32'(mem_wena), 32'h1);
    chk("t5_wr_wdata", mem_wdata,     32'h11);
    step;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t5_rsp_rdata", rsp_rdata,      32'h10);
    step;
    cmd_write = 1'b0;
`endif

    // T6 async reset during an access
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h010;
    step;
    cmd_valid = 1'b0;
    chk("t6_acc_ena", 32'(mem_ena), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ena",   32'(mem_ena),   32'h0);
    chk("t6_rst_rspv",  32'(rsp_valid), 32'h0);
    chk("t6_rst_busy",  32'(busy),      32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step;
    chk("t6_idle_busy",  32'(busy),      32'h0);
    chk("t6_idle_ready", 32'(cmd_ready), 32'h1);
    chk("t6_idle_ena",   32'(mem_ena),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
